// File: rtl/game_flow_controller.sv
`default_nettype none
// ============================================================================
// Module   : game_flow_controller
// Purpose  : PAC-MAN game-state sequencer (state FSM, power timer, ghost combo,
//            score, lives and dot count), advanced once per game tick.
// Revision : 1.0 - initial release
// ============================================================================
module game_flow_controller #(
    parameter int LIVES         = 3,
    parameter int MAX_DOTS      = 240,
    parameter int POWER_TICKS   = 8,
    parameter int DEATH_TICKS   = 5,
    parameter int DOT_POINTS    = 10,
    parameter int BIGDOT_POINTS = 50,
    parameter int GHOST_POINTS  = 200,
    parameter int SCORE_MAX     = 999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        start_key,
    input  logic        dot_eaten,
    input  logic        big_dot_eaten,
    input  logic [3:0]  ghost_hit,
    output logic [2:0]  game_state,
    output logic        power_active,
    output logic [3:0]  power_remaining,
    output logic [3:0]  ghost_respawn,
    output logic        actors_reset,
    output logic        map_reload,
    output logic [19:0] score,
    output logic [1:0]  lives,
    output logic [8:0]  dots_eaten
);

    localparam int c_death_w = $clog2(DEATH_TICKS + 1) + 1;

    typedef enum logic [2:0] {
        ST_STANDBY  = 3'd0,
        ST_PLAYING  = 3'd1,
        ST_POWER    = 3'd2,
        ST_DYING    = 3'd3,
        ST_GAMEOVER = 3'd4,
        ST_WIN      = 3'd5
    } state_t;

    state_t               r_state;
    logic                 r_start_prev;
    logic [1:0]           r_combo;
    logic [c_death_w-1:0] r_death_timer;

    logic        w_start_edge;
    logic [1:0]  w_combo_after;
    logic [12:0] w_ghost_pts;
    logic [12:0] w_tick_pts;
    logic [9:0]  w_dots_sum;
    logic [20:0] w_score_sum;
    logic [19:0] w_score_sat;
    logic        w_win;

    assign game_state   = r_state;
    assign power_active = (r_state == ST_POWER);
    assign w_start_edge = start_key & ~r_start_prev;

    // Ghosts are scored in ascending index order, each doubling the next one's value.
    always_comb begin
        w_ghost_pts   = '0;
        w_combo_after = r_combo;
        for (int i = 0; i < 4; i++) begin
            if (ghost_hit[i]) begin
                w_ghost_pts = w_ghost_pts + 13'(GHOST_POINTS << w_combo_after);
                if (w_combo_after != 2'd3)
                    w_combo_after = w_combo_after + 2'd1;
            end
        end
        w_tick_pts = (dot_eaten     ? 13'(DOT_POINTS)    : 13'd0)
                   + (big_dot_eaten ? 13'(BIGDOT_POINTS) : 13'd0)
                   + ((r_state == ST_POWER) ? w_ghost_pts : 13'd0);
        w_dots_sum  = {1'b0, dots_eaten} + {9'd0, dot_eaten} + {9'd0, big_dot_eaten};
        w_score_sum = {1'b0, score} + {8'd0, w_tick_pts};
        w_score_sat = (w_score_sum > 21'(SCORE_MAX)) ? 20'(SCORE_MAX) : w_score_sum[19:0];
        w_win       = (w_dots_sum >= 10'(MAX_DOTS));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= ST_STANDBY;
            r_start_prev    <= 1'b0;
            r_combo         <= 2'd0;
            r_death_timer   <= '0;
            power_remaining <= 4'd0;
            ghost_respawn   <= 4'd0;
            actors_reset    <= 1'b0;
            map_reload      <= 1'b0;
            score           <= 20'd0;
            lives           <= 2'(LIVES);
            dots_eaten      <= 9'd0;
        end else begin
            ghost_respawn <= 4'd0;
            actors_reset  <= 1'b0;
            map_reload    <= 1'b0;
            if (tick) begin
                r_start_prev <= start_key;
                case (r_state)
                    ST_STANDBY: begin
                        if (w_start_edge) begin
                            r_state      <= ST_PLAYING;
                            map_reload   <= 1'b1;
                            actors_reset <= 1'b1;
                        end
                    end
                    ST_PLAYING, ST_POWER: begin
                        score      <= w_score_sat;
                        dots_eaten <= w_dots_sum[8:0];
                        if (r_state == ST_POWER)
                            ghost_respawn <= ghost_hit;
                        // Clearing the level wins even on a tick that would otherwise kill.
                        if (w_win) begin
                            r_state         <= ST_WIN;
                            power_remaining <= 4'd0;
                            r_combo         <= 2'd0;
                        end else if (r_state == ST_PLAYING && |ghost_hit) begin
                            r_state       <= ST_DYING;
                            r_death_timer <= c_death_w'(DEATH_TICKS);
                            actors_reset  <= 1'b1;
                            if (lives != 2'd0)
                                lives <= lives - 2'd1;
                        end else if (big_dot_eaten) begin
                            r_state         <= ST_POWER;
                            power_remaining <= 4'(POWER_TICKS);
                            r_combo         <= 2'd0;
                        end else if (r_state == ST_POWER) begin
                            r_combo <= w_combo_after;
                            if (power_remaining == 4'd0) begin
                                r_state <= ST_PLAYING;
                                r_combo <= 2'd0;
                            end else begin
                                power_remaining <= power_remaining - 4'd1;
                            end
                        end
                    end
                    ST_DYING: begin
                        if (r_death_timer <= c_death_w'(1)) begin
                            r_death_timer <= '0;
                            if (lives == 2'd0) begin
                                r_state <= ST_GAMEOVER;
                            end else begin
                                r_state      <= ST_PLAYING;
                                actors_reset <= 1'b1;
                            end
                        end else begin
                            r_death_timer <= r_death_timer - c_death_w'(1);
                        end
                    end
                    ST_GAMEOVER, ST_WIN: begin
                        if (w_start_edge) begin
                            r_state    <= ST_STANDBY;
                            score      <= 20'd0;
                            lives      <= 2'(LIVES);
                            dots_eaten <= 9'd0;
                            r_combo    <= 2'd0;
                            map_reload <= 1'b1;
                        end
                    end
                    default: r_state <= ST_STANDBY;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
